// File: rtl/state_stepper.sv
// state_stepper: two-button (up/down) state index stepper.
// Raw buttons are synchronised and debounced against tick_mf. Presses or
// releases (EDGE_MODE) step a registered index through NUM_STATES values,
// with wrap or saturate at the ends and optional long-press auto-repeat.
module state_stepper #(
  parameter int NUM_STATES     = 4,
  parameter int STATE_W        = 2,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int EDGE_MODE      = 1,
  parameter int WRAP           = 1,
  parameter int HOLD_TICKS     = 500,
  parameter int REPEAT_TICKS   = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_mf,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [STATE_W-1:0] state,
  output logic               step,
  output logic               dir
);

  // Button lanes: bit 1 = up, bit 0 = down.
  localparam int DB_W     = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_TGT  = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0]  REP_TGT   = HOLD_W'(REPEAT_TICKS);
  localparam logic [STATE_W-1:0] MAX_STATE = STATE_W'(NUM_STATES - 1);

  logic [1:0]        w_raw;
  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        r_stable;
  logic [1:0]        r_stable_d;
  logic [1:0]        r_repeated;
  logic [DB_W-1:0]   r_db_cnt [2];
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_rep_phase;

  logic [1:0]         w_press;
  logic [1:0]         w_release;
  logic [1:0]         w_edge_req;
  logic [1:0]         w_fire;
  logic [1:0]         w_req;
  logic               w_one_held;
  logic [HOLD_W-1:0]  w_hold_next;
  logic [HOLD_W-1:0]  w_hold_tgt;
  logic               w_hold_hit;
  logic               w_go_up;
  logic               w_go_dn;
  logic [STATE_W-1:0] w_state_next;
  logic               w_step_next;

  assign w_raw = {btn_up, btn_down};

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: flip the stable level after DEBOUNCE_TICKS ticks of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      // NOTE: this counter array is ordinary flops, not a RAM, so it is reset like any register.
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_stable[b]) begin
          r_db_cnt[b] <= '0;
        end else if (tick_mf) begin
          if (r_db_cnt[b] == DB_LAST) begin
            r_stable[b] <= r_sync2[b];
            r_db_cnt[b] <= '0;
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
          end
        end
      end
    end
  end

  assign w_press   = r_stable & ~r_stable_d;
  assign w_release = ~r_stable & r_stable_d;

  // Auto-repeat timing: first hit after HOLD_TICKS, then every REPEAT_TICKS.
  assign w_one_held  = r_stable[1] ^ r_stable[0];
  assign w_hold_next = r_hold_cnt + HOLD_W'(1);
  assign w_hold_tgt  = r_rep_phase ? REP_TGT : HOLD_TGT;
  assign w_hold_hit  = (HOLD_TICKS != 0) && w_one_held && tick_mf && (w_hold_next == w_hold_tgt);
  assign w_fire      = w_hold_hit ? r_stable : 2'b00;

  // Hold counter runs only while exactly one button is stably pressed.
  always_ff @(posedge clk) begin
    if (rst || !w_one_held || (HOLD_TICKS == 0)) begin
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b0;
    end else if (tick_mf) begin
      if (w_hold_hit) begin
        r_hold_cnt  <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_hold_cnt <= w_hold_next;
      end
    end
  end

  // Edge-detect copy of stable and per-button "auto-repeat happened" flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable_d <= '0;
      r_repeated <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int b = 0; b < 2; b++) begin
        if (w_release[b])   r_repeated[b] <= 1'b0;
        else if (w_fire[b]) r_repeated[b] <= 1'b1;
      end
    end
  end

  // A release after an auto-repeat hold is swallowed so the hold ends cleanly.
  assign w_edge_req = (EDGE_MODE != 0) ? (w_release & ~r_repeated) : w_press;
  assign w_req      = w_edge_req | w_fire;
  assign w_go_up    = w_req[1] & ~w_req[0];
  assign w_go_dn    = w_req[0] & ~w_req[1];

  // Next-state arithmetic with wrap/saturate; opposing requests cancel.
  always_comb begin
    // NOTE: always_comb uses blocking = with defaults first, so no latch is inferred.
    w_state_next = state;
    w_step_next  = 1'b0;
    if (w_go_up) begin
      if (state == MAX_STATE) begin
        if (WRAP != 0) begin
          w_state_next = '0;
          w_step_next  = 1'b1;
        end
      end else begin
        w_state_next = state + STATE_W'(1);
        w_step_next  = 1'b1;
      end
    end else if (w_go_dn) begin
      if (state == '0) begin
        if (WRAP != 0) begin
          w_state_next = MAX_STATE;
          w_step_next  = 1'b1;
        end
      end else begin
        w_state_next = state - STATE_W'(1);
        w_step_next  = 1'b1;
      end
    end
  end

  // Registered outputs; dir only moves on a real step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      step  <= 1'b0;
      dir   <= 1'b0;
    end else begin
      state <= w_state_next;
      step  <= w_step_next;
      if (w_step_next) dir <= w_go_up;
    end
  end

endmodule

// File: tb/tb_state_stepper.sv
// Testbench for state_stepper: three parameterisations driven by directed
// button vectors; expected steps are queued and checked by per-DUT monitors.
module tb_state_stepper;

  typedef struct packed {
    logic [2:0] st;
    logic       dir;
  } exp_t;

  // Button vector indices.
  localparam int A_UP = 0, A_DN = 1, B_UP = 2, B_DN = 3, C_UP = 4, C_DN = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_c = 1'b1;
  logic       tick_mf = 1'b0;
  logic [5:0] btns = '0;

  logic [2:0] a_state, c_state;
  logic [1:0] b_state;
  logic       a_step, b_step, c_step;
  logic       a_dir, b_dir, c_dir;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;

  // tick_mf: one clk high every 4 clks, changed on the falling edge.
  initial begin
    int k = 0;
    forever begin
      @(negedge clk);
      tick_mf = (k % 4 == 0);
      k++;
    end
  end

  // A: 5 states, wrap, step on release, auto-repeat 10/4.
  state_stepper #(.NUM_STATES(5), .STATE_W(3), .DEBOUNCE_TICKS(3), .EDGE_MODE(1),
                  .WRAP(1), .HOLD_TICKS(10), .REPEAT_TICKS(4)) dut_a (
    .clk(clk), .rst(rst), .tick_mf(tick_mf), .btn_up(btns[A_UP]), .btn_down(btns[A_DN]),
    .state(a_state), .step(a_step), .dir(a_dir));

  // B: 3 states, saturate, step on release, no auto-repeat.
  state_stepper #(.NUM_STATES(3), .STATE_W(2), .DEBOUNCE_TICKS(3), .EDGE_MODE(1),
                  .WRAP(0), .HOLD_TICKS(0), .REPEAT_TICKS(4)) dut_b (
    .clk(clk), .rst(rst), .tick_mf(tick_mf), .btn_up(btns[B_UP]), .btn_down(btns[B_DN]),
    .state(b_state), .step(b_step), .dir(b_dir));

  // C: 5 states, wrap, step on press, auto-repeat 10/4, own reset.
  state_stepper #(.NUM_STATES(5), .STATE_W(3), .DEBOUNCE_TICKS(3), .EDGE_MODE(0),
                  .WRAP(1), .HOLD_TICKS(10), .REPEAT_TICKS(4)) dut_c (
    .clk(clk), .rst(rst_c), .tick_mf(tick_mf), .btn_up(btns[C_UP]), .btn_down(btns[C_DN]),
    .state(c_state), .step(c_step), .dir(c_dir));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input logic [31:0] st, input logic d);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected step to state %0d dir %0d, none queued", name, st, d);
  endtask

  // Monitors: every step pulse must match the next queued {state, dir}.
  always @(negedge clk) begin
    exp_t e;
    if (a_step) begin
      if (q_a.size() == 0) spurious("a_step", 32'(a_state), a_dir);
      else begin
        e = q_a.pop_front();
        check("a_step state/dir", 32'({a_state, a_dir}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_step) begin
      if (q_b.size() == 0) spurious("b_step", 32'(b_state), b_dir);
      else begin
        e = q_b.pop_front();
        check("b_step state/dir", 32'({1'b0, b_state, b_dir}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (c_step) begin
      if (q_c.size() == 0) spurious("c_step", 32'(c_state), c_dir);
      else begin
        e = q_c.pop_front();
        check("c_step state/dir", 32'({c_state, c_dir}), 32'(e));
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold button idx high for hi ticks, then low for lo ticks (4 clk per tick).
  task automatic press(input int idx, input int hi, input int lo);
    btns[idx] = 1'b1;
    clks(4 * hi);
    btns[idx] = 1'b0;
    clks(4 * lo);
  endtask

  task automatic push(input int which, input logic [2:0] st, input logic d);
    exp_t e;
    e.st  = st;
    e.dir = d;
    case (which)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  initial begin
    clks(3);
    rst   = 1'b0;
    rst_c = 1'b0;
    check("a reset state", 32'(a_state), 0);
    check("a reset step/dir", 32'({a_step, a_dir}), 0);
    check("b reset state", 32'(b_state), 0);
    check("c reset state/step/dir", 32'({c_state, c_step, c_dir}), 0);

    // 1: six clean up press/releases on A, release-triggered with wrap.
    push(0, 3'd1, 1'b1); push(0, 3'd2, 1'b1); push(0, 3'd3, 1'b1);
    push(0, 3'd4, 1'b1); push(0, 3'd0, 1'b1); push(0, 3'd1, 1'b1);
    for (int i = 0; i < 6; i++) press(A_UP, 6, 6);
    check("a after 6 ups pending", q_a.size(), 0);
    check("a after 6 ups state", 32'(a_state), 1);

    // 2: bounce (1 tick high, 1 low, 5 high) gives one step; 2-tick glitch gives none.
    push(0, 3'd2, 1'b1);
    press(A_UP, 1, 1);
    press(A_UP, 5, 6);
    press(A_UP, 2, 6);
    check("a bounce pending", q_a.size(), 0);
    check("a after bounce state", 32'(a_state), 2);

    // Down on A, including wrap from 0 to 4.
    push(0, 3'd1, 1'b0); push(0, 3'd0, 1'b0); push(0, 3'd4, 1'b0);
    for (int i = 0; i < 3; i++) press(A_DN, 6, 6);
    check("a down wrap pending", q_a.size(), 0);
    check("a down wrap dir", 32'(a_dir), 0);

    // 3: saturate on B: 4 ups then 3 downs.
    push(1, 3'd1, 1'b1); push(1, 3'd2, 1'b1);
    for (int i = 0; i < 4; i++) press(B_UP, 6, 6);
    check("b sat top pending", q_b.size(), 0);
    check("b sat top state/dir", 32'({b_state, b_dir}), 32'({2'd2, 1'b1}));
    push(1, 3'd1, 1'b0); push(1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) press(B_DN, 6, 6);
    check("b sat bottom pending", q_b.size(), 0);
    check("b sat bottom state/dir", 32'({b_state, b_dir}), 0);

    // 4a: C press-triggered hold 24 ticks from 0: press + repeats at 10,14,18,22.
    push(2, 3'd1, 1'b1); push(2, 3'd2, 1'b1); push(2, 3'd3, 1'b1);
    push(2, 3'd4, 1'b1); push(2, 3'd0, 1'b1);
    press(C_UP, 24, 8);
    check("c hold repeat pending", q_c.size(), 0);
    check("c hold repeat state", 32'(c_state), 0);

    // 4b: A release-triggered hold from 4: repeats only, no release step.
    push(0, 3'd0, 1'b1); push(0, 3'd1, 1'b1); push(0, 3'd2, 1'b1); push(0, 3'd3, 1'b1);
    press(A_UP, 24, 8);
    check("a hold repeat pending", q_a.size(), 0);
    check("a hold repeat state", 32'(a_state), 3);

    // 5: both buttons together, held past HOLD_TICKS: nothing happens.
    btns[A_UP] = 1'b1;
    btns[A_DN] = 1'b1;
    clks(4 * 24);
    btns[A_UP] = 1'b0;
    btns[A_DN] = 1'b0;
    clks(4 * 8);
    check("a both buttons state", 32'(a_state), 3);
    check("a both buttons dir", 32'(a_dir), 1);

    // 6: reset C mid-hold at state 3; held button re-presses to 1.
    push(2, 3'd1, 1'b1); push(2, 3'd2, 1'b1);
    press(C_UP, 6, 6);
    press(C_UP, 6, 6);
    push(2, 3'd3, 1'b1);
    btns[C_UP] = 1'b1;
    clks(4 * 8);
    check("c pre-reset state", 32'(c_state), 3);
    rst_c = 1'b1;
    clks(1);
    rst_c = 1'b0;
    check("c mid-hold reset state/step/dir", 32'({c_state, c_step, c_dir}), 0);
    push(2, 3'd1, 1'b1);
    clks(4 * 8);
    btns[C_UP] = 1'b0;
    clks(4 * 8);
    check("c post-reset pending", q_c.size(), 0);
    check("c post-reset state/dir", 32'({c_state, c_dir}), 32'({3'd1, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
